ar_demux_sched: RTL
===================

AR_DEMUX_SCHED -- requirements
Module: ar_demux_sched

Interface
REQ-001 Parameter BURST_LEN, default 4: beats per grant, legal range 1..255.
REQ-002 Parameter DW, default 1: data width.
REQ-003 Parameter TIMEOUT, default 16: stall limit in cycles, legal range 1..255.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  source has a beat on in_data.
REQ-007 in_data  in  DW  source beat.
REQ-008 in_ready  out  1  block accepts the beat this cycle; combinational.
REQ-009 dst_ready  in  4  per-destination ready; bit i means output y[i] is able to take data.
REQ-010 sel  out  2  demux select; registered.
REQ-011 enable  out  1  demux enable; registered; one-cycle pulse per beat.
REQ-012 a  out  DW  demux data input; registered.
REQ-013 grant  out  4  one-hot current owner; all zeros when not in XFER.
REQ-014 busy  out  1  high while state is XFER.
REQ-015 timeout  out  1  one-cycle pulse on stall abort (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE and XFER only.
REQ-017 IDLE with dst_ready==0: stay in IDLE; in_ready=0.
REQ-018 IDLE with dst_ready!=0: select the first set bit in order last+1, last+2, last+3, last (mod 4), load sel, set last=sel, clear beat_cnt, go to XFER next cycle.
REQ-019 XFER: in_ready = dst_ready[sel]; a beat occurs when in_valid && in_ready.
REQ-020 On a beat: the next cycle enable=1, a=beat data, and sel unchanged; beat_cnt increments.
REQ-021 No beat in a cycle: the next cycle enable=0; a holds its previous value.
REQ-022 When the beat that makes beat_cnt==BURST_LEN occurs, go to IDLE; that beat's enable pulse is emitted in the first IDLE cycle.
REQ-023 sel SHALL change only on the IDLE->XFER transition, so it is stable for every enable pulse.
REQ-024 Consecutive beats in XFER SHALL be accepted back-to-back, one per cycle; there are no bubbles when in_valid and dst_ready[sel] stay high.
REQ-025 dst_ready[sel] falling mid-burst stalls the burst (in_ready=0); transfer resumes when it rises, and beat_cnt is retained.
REQ-026 Changes in other dst_ready bits during XFER SHALL have no effect until the next IDLE.
REQ-027 Minimum gap between bursts is one IDLE cycle; the maximum wait for any continuously ready destination is 3 bursts.

Reset
REQ-028 On rst_n low, immediately and asynchronously: state=IDLE, sel=0, enable=0, a=0, grant=0, busy=0, timeout=0, beat_cnt=0, stall_cnt=0, last=3.
REQ-029 Reset asserted mid-burst discards the remaining beats; the first grant after reset goes to the lowest set dst_ready bit.

Configuration
REQ-030 Macro AR_SCHED_TIMEOUT_EN defined: in XFER, stall_cnt counts cycles without a beat and clears on each beat.
REQ-031 With the macro defined, when stall_cnt reaches TIMEOUT: go to IDLE, pulse timeout for one cycle, and discard the remaining beats.
REQ-032 Macro undefined: timeout is tied to 0, no stall counter exists, and a stall lasts indefinitely.

Verification
REQ-033 Reset, then dst_ready=4'b0001, in_valid=1, BURST_LEN=4 -> sel=0, grant=0001, four consecutive enable pulses with a equal to the 4 beats, then IDLE.
REQ-034 dst_ready=4'b1111 held, in_valid=1 -> bursts granted in order sel 0,1,2,3,0, each 4 beats, with one idle cycle between bursts.
REQ-035 Mid-burst after 2 beats, drop dst_ready[sel] for 5 cycles -> in_ready=0 and no enable pulses during the drop; then 2 more beats; total 4 pulses.
REQ-036 AR_SCHED_TIMEOUT_EN, TIMEOUT=16, stall for 20 cycles -> timeout pulses on the 16th stall cycle, grant=0 on the next cycle, and the next grant goes to the next ready destination.
REQ-037 rst_n pulsed low after beat 1 of a burst -> all outputs zero the same cycle; after release with dst_ready=4'b0110, first grant has sel=1.

Source files
------------

// File: rtl/ar_demux_sched.sv
// Round-robin burst scheduler that feeds a 1-to-4 demux. The optional stall
// abort is enabled by defining AR_SCHED_TIMEOUT_EN.
module ar_demux_sched #(
   parameter int BURST_LEN = 4,
   parameter int DW        = 1,
   parameter int TIMEOUT   = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   input  logic [3:0]    dst_ready,
   output logic [1:0]    sel,
   output logic          enable,
   output logic [DW-1:0] a,
   output logic [3:0]    grant,
   output logic          busy,
   output logic          timeout
);

   typedef enum logic {IDLE, XFER} state_t;

   state_t     state;
   logic [1:0] last;
   logic [1:0] pick;
   logic [1:0] cand;
   logic       found;
   logic [7:0] beat_cnt;
   logic       beat;
   logic       stall_hit;

   assign in_ready = (state == XFER) && dst_ready[sel];
   assign beat     = in_valid && in_ready;
   assign busy     = (state == XFER);
   assign grant    = busy ? (4'b0001 << sel) : 4'b0000;

   // Search starts just after the previous owner and wraps back to it last.
   always_comb begin
      pick  = last;
      cand  = last;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         cand = last + 2'(k);
         if (!found && dst_ready[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sel      <= 2'd0;
         enable   <= 1'b0;
         a        <= '0;
         last     <= 2'd3;
         beat_cnt <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               enable <= 1'b0;
               if (dst_ready != 4'b0000) begin
                  sel      <= pick;
                  last     <= pick;
                  beat_cnt <= 8'd0;
                  state    <= XFER;
               end
            end
            XFER: begin
               enable <= beat;
               if (beat) begin
                  a        <= in_data;
                  beat_cnt <= beat_cnt + 8'd1;
                  if (beat_cnt == 8'(BURST_LEN - 1))
                     state <= IDLE;
               end else if (stall_hit) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef AR_SCHED_TIMEOUT_EN
   logic [7:0] stall_cnt;
   logic       timeout_q;

   assign stall_hit = (state == XFER) && !beat && (stall_cnt == 8'(TIMEOUT - 1));
   assign timeout   = timeout_q;

   // Stall counter only runs while a granted burst is waiting on a beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= stall_hit;
         if ((state != XFER) || beat || stall_hit)
            stall_cnt <= 8'd0;
         else
            stall_cnt <= stall_cnt + 8'd1;
      end
   end
`else
   assign stall_hit = 1'b0;
   assign timeout   = 1'b0;
`endif

endmodule
